// File: rtl/mips_xlat_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_xlat_issue_ctrl
// Purpose  : Sequencer between the MIPS fetch stream and the MIPS-to-RISC-V
//            translation datapath. It accepts one MIPS instruction at a time,
//            launches a translation, and collects the 1 or 2 RISC-V words the
//            translator emits. Those words are committed atomically into an
//            output FIFO that feeds the RISC-V core. It also reports
//            illegal-instruction, timeout and overflow errors, and supports a
//            synchronous pipeline flush.
// Ports    : clk, reset (async, active-high), flush
//            in_valid/in_ready/in_instr/in_pc   - MIPS instruction intake
//            xl_start/xl_instr                  - translator launch
//            xl_word_valid/xl_word/xl_last/xl_illegal - translator results
//            out_valid/out_ready/out_instr/out_pc/out_first - FIFO head to core
//            err_valid/err_code/err_pc          - one-cycle error report
//            busy, fifo_count                   - status
// Revision : 1.0 - initial release
// ============================================================================
module mips_xlat_issue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_instr,
    input  logic [31:0]                 in_pc,
    output logic                        xl_start,
    output logic [31:0]                 xl_instr,
    input  logic                        xl_word_valid,
    input  logic [31:0]                 xl_word,
    input  logic                        xl_last,
    input  logic                        xl_illegal,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_instr,
    output logic [31:0]                 out_pc,
    output logic                        out_first,
    output logic                        err_valid,
    output logic [1:0]                  err_code,
    output logic [31:0]                 err_pc,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    // Highest occupancy that still leaves room for a two-word commit.
    localparam logic [CNT_W-1:0] c_ACCEPT_MAX = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [TMR_W-1:0] c_TMR_LAST   = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] c_ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] c_ERR_OVERFLOW = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_COLLECT = 2'd2,
        S_ERR     = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    state_t             state_q;
    logic [31:0]        instr_q;
    logic [31:0]        pc_q;
    logic [31:0]        stage0_q;
    logic [1:0]         stage_cnt_q;
    logic [TMR_W-1:0]   timer_q;
    logic               xl_start_q;
    logic               err_valid_q;
    logic [1:0]         err_code_q;

    // ------------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------------
    logic [31:0]        mem_instr_q [FIFO_DEPTH];
    logic [31:0]        mem_pc_q    [FIFO_DEPTH];
    logic               mem_first_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    logic               w_commit;
    logic               w_two;
    logic [CNT_W-1:0]   w_push_n;
    logic [31:0]        w_slot0_instr;
    logic               w_pop;
    logic [PTR_W-1:0]   w_wr_ptr_p1;

    // ------------------------------------------------------------------------
    // Intake handshake
    // ------------------------------------------------------------------------
    assign in_ready = !reset && (state_q == S_IDLE) && !flush && (count_q <= c_ACCEPT_MAX);

    // ------------------------------------------------------------------------
    // Commit decode. A final word arriving with one word already staged
    // yields a two-entry commit; the final word always comes straight from
    // xl_word, so only the first staged word ever needs storage. A second
    // non-final word just advances the staging count so a third word can be
    // recognised as an overflow.
    // ------------------------------------------------------------------------
    always_comb begin
        w_commit      = (state_q == S_COLLECT) && !xl_illegal && xl_word_valid
                        && xl_last && (stage_cnt_q != 2'd2);
        w_two         = (stage_cnt_q == 2'd1);
        w_push_n      = '0;
        if (w_commit) begin
            w_push_n = w_two ? CNT_W'(2) : CNT_W'(1);
        end
        w_slot0_instr = w_two ? stage0_q : xl_word;
        w_pop         = out_valid && out_ready;
        w_wr_ptr_p1   = wr_ptr_q + PTR_W'(1);
        count_d       = count_q + w_push_n - (w_pop ? CNT_W'(1) : CNT_W'(0));
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM with registered launch and error outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            pc_q        <= '0;
            stage0_q    <= '0;
            stage_cnt_q <= '0;
            timer_q     <= '0;
            xl_start_q  <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            xl_start_q  <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            if (flush) begin
                // Flush overrides any transition, including one into ERR,
                // so a pending error pulse never appears.
                state_q     <= S_IDLE;
                stage_cnt_q <= '0;
                timer_q     <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (in_valid && in_ready) begin
                            instr_q    <= in_instr;
                            pc_q       <= in_pc;
                            xl_start_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        stage_cnt_q <= '0;
                        timer_q     <= '0;
                        state_q     <= S_COLLECT;
                    end
                    S_COLLECT: begin
                        if (xl_illegal) begin
                            stage_cnt_q <= '0;
                            err_valid_q <= 1'b1;
                            err_code_q  <= c_ERR_ILLEGAL;
                            state_q     <= S_ERR;
                        end else if (xl_word_valid) begin
                            timer_q <= '0;
                            if (stage_cnt_q == 2'd2) begin
                                stage_cnt_q <= '0;
                                err_valid_q <= 1'b1;
                                err_code_q  <= c_ERR_OVERFLOW;
                                state_q     <= S_ERR;
                            end else if (xl_last) begin
                                stage_cnt_q <= '0;
                                state_q     <= S_IDLE;
                            end else begin
                                if (stage_cnt_q == 2'd0) begin
                                    stage0_q <= xl_word;
                                end
                                stage_cnt_q <= stage_cnt_q + 2'd1;
                            end
                        end else if (timer_q == c_TMR_LAST) begin
                            // This idle cycle is the TIMEOUT-th in a row.
                            stage_cnt_q <= '0;
                            err_valid_q <= 1'b1;
                            err_code_q  <= c_ERR_TIMEOUT;
                            state_q     <= S_ERR;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end
                    S_ERR: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + w_push_n[PTR_W-1:0];
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // FIFO data array; no reset needed since entries are only read when valid.
    always_ff @(posedge clk) begin
        if (w_commit && !flush && !reset) begin
            mem_instr_q[wr_ptr_q] <= w_slot0_instr;
            mem_pc_q[wr_ptr_q]    <= pc_q;
            mem_first_q[wr_ptr_q] <= 1'b1;
            if (w_two) begin
                mem_instr_q[w_wr_ptr_p1] <= xl_word;
                mem_pc_q[w_wr_ptr_p1]    <= pc_q;
                mem_first_q[w_wr_ptr_p1] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Head data is forced to zero while empty so every output is 0
    // during reset.
    // ------------------------------------------------------------------------
    assign out_valid  = (count_q != '0);
    assign out_instr  = out_valid ? mem_instr_q[rd_ptr_q] : '0;
    assign out_pc     = out_valid ? mem_pc_q[rd_ptr_q]    : '0;
    assign out_first  = out_valid ? mem_first_q[rd_ptr_q] : 1'b0;
    assign fifo_count = count_q;
    assign xl_start   = xl_start_q;
    assign xl_instr   = instr_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_pc     = err_valid_q ? pc_q : '0;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mips_xlat_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_xlat_issue_ctrl
// Purpose  : Self-checking bench for mips_xlat_issue_ctrl. Directed scenarios
//            plus a randomized transaction mix scored against a
//            transaction-level model (expected FIFO entries and error events).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_xlat_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        first;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        xl_start;
    logic [31:0] xl_instr;
    logic        xl_word_valid = 1'b0;
    logic [31:0] xl_word = '0;
    logic        xl_last = 1'b0;
    logic        xl_illegal = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_first;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [31:0] err_pc;
    logic        busy;
    logic [2:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit rnd_ready_en = 1'b0;

    ent_t        exp_q[$];
    ent_t        got_q[$];
    logic [33:0] exp_err[$];
    logic [33:0] got_err[$];

    mips_xlat_issue_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .xl_start(xl_start), .xl_instr(xl_instr),
        .xl_word_valid(xl_word_valid), .xl_word(xl_word), .xl_last(xl_last),
        .xl_illegal(xl_illegal),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_first(out_first),
        .err_valid(err_valid), .err_code(err_code), .err_pc(err_pc),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Record popped entries and error pulses, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (out_valid && out_ready) got_q.push_back(ent_t'({out_instr, out_pc, out_first}));
            if (err_valid) got_err.push_back({err_code, err_pc});
        end
    end

    // Random core backpressure, enabled only by the random test.
    initial forever begin
        @(posedge clk); #1;
        if (rnd_ready_en) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) tick();
    endtask

    // Present an instruction until accepted; returns in the ISSUE cycle.
    task automatic accept(input logic [31:0] ins, input logic [31:0] pc, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
        for (int n = 0; n < 300; n++) begin
            #1;
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        xl_word_valid = 1'b1; xl_word = w; xl_last = last;
        tick();
        xl_word_valid = 1'b0; xl_last = 1'b0;
    endtask

    // One whole transaction of a given kind; the model records what the
    // translation rules say must come out.
    // kind 0: one word, 1: two words, 2: illegal, 3: three words, 4: silence
    task automatic drive_instr(input int kind, input logic [31:0] pc, output bit ok);
        logic [31:0] w0, w1, w2;
        w0 = $urandom; w1 = $urandom; w2 = $urandom;
        accept($urandom, pc, ok);
        if (!ok) return;
        tick();
        case (kind)
            0: begin
                send_word(w0, 1'b1);
                exp_q.push_back('{w0, pc, 1'b1});
            end
            1: begin
                gap(); send_word(w0, 1'b0);
                gap(); send_word(w1, 1'b1);
                exp_q.push_back('{w0, pc, 1'b1});
                exp_q.push_back('{w1, pc, 1'b0});
            end
            2: begin
                if ($urandom_range(0, 1) == 1) begin gap(); send_word(w0, 1'b0); end
                gap();
                xl_illegal = 1'b1;
                xl_word_valid = 1'($urandom_range(0, 1)); xl_word = w1; xl_last = 1'b1;
                tick();
                xl_illegal = 1'b0; xl_word_valid = 1'b0; xl_last = 1'b0;
                exp_err.push_back({2'b01, pc});
            end
            3: begin
                send_word(w0, 1'b0); gap();
                send_word(w1, 1'b0); gap();
                send_word(w2, 1'($urandom_range(0, 1)));
                exp_err.push_back({2'b11, pc});
            end
            default: begin
                repeat (TMO + 1) tick();
                exp_err.push_back({2'b10, pc});
            end
        endcase
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_tests++; if ({out_valid, busy, xl_start, err_valid, fifo_count} !== 7'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%b exp=0", {out_valid, busy, xl_start, err_valid, fifo_count}); end
        reset = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single_word();
        bit ok;
        out_ready = 1'b0;
        accept(32'h01095020, 32'h100, ok);
        n_tests++; if (!(ok && xl_start === 1'b1 && xl_instr === 32'h01095020)) begin
            n_fail++; $display("FAIL single_issue got start=%b instr=%h exp start=1 instr=01095020", xl_start, xl_instr); end
        tick();
        n_tests++; if (xl_start !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse got=%b exp=0", xl_start); end
        send_word(32'h00A48533, 1'b1);
        n_tests++; if ({out_valid, out_instr, out_pc, out_first, fifo_count} !== {1'b1, 32'h00A48533, 32'h100, 1'b1, 3'd1}) begin
            n_fail++; $display("FAIL single_head got v=%b i=%h pc=%h f=%b c=%0d exp v=1 i=00A48533 pc=100 f=1 c=1",
                               out_valid, out_instr, out_pc, out_first, fifo_count); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_pop got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_two_word();
        bit ok;
        accept($urandom, 32'h200, ok);
        tick();
        send_word(32'h123452B7, 1'b0);
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL two_staged got=%0d exp=0", fifo_count); end
        send_word(32'h67828293, 1'b1);
        n_tests++; if ({fifo_count, out_instr, out_pc, out_first} !== {3'd2, 32'h123452B7, 32'h200, 1'b1}) begin
            n_fail++; $display("FAIL two_head0 got c=%0d i=%h pc=%h f=%b exp c=2 i=123452B7 pc=200 f=1",
                               fifo_count, out_instr, out_pc, out_first); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_tests++; if ({fifo_count, out_instr, out_pc, out_first} !== {3'd1, 32'h67828293, 32'h200, 1'b0}) begin
            n_fail++; $display("FAIL two_head1 got c=%0d i=%h pc=%h f=%b exp c=1 i=67828293 pc=200 f=0",
                               fifo_count, out_instr, out_pc, out_first); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b0;
        drive_instr(0, 32'h1000, ok);
        drive_instr(1, 32'h1004, ok);
        #1;
        n_tests++; if ({fifo_count, in_ready} !== {3'd3, 1'b0}) begin
            n_fail++; $display("FAIL bp_full got c=%0d rdy=%b exp c=3 rdy=0", fifo_count, in_ready); end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0; #1;
        n_tests++; if ({fifo_count, in_ready} !== {3'd2, 1'b1}) begin
            n_fail++; $display("FAIL bp_pop got c=%0d rdy=%b exp c=2 rdy=1", fifo_count, in_ready); end
        out_ready = 1'b1; repeat (4) tick(); out_ready = 1'b0;
        n_tests++; if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_illegal();
        bit ok;
        out_ready = 1'b0;
        drive_instr(0, 32'h2000, ok);
        accept($urandom, 32'h300, ok);
        tick();
        send_word($urandom, 1'b0);
        xl_illegal = 1'b1; xl_word_valid = 1'b1; xl_last = 1'b1;
        tick();
        xl_illegal = 1'b0; xl_word_valid = 1'b0; xl_last = 1'b0;
        n_tests++; if ({err_valid, err_code, err_pc, fifo_count} !== {1'b1, 2'b01, 32'h300, 3'd1}) begin
            n_fail++; $display("FAIL illegal_err got v=%b code=%b pc=%h c=%0d exp v=1 code=01 pc=300 c=1",
                               err_valid, err_code, err_pc, fifo_count); end
        tick();
        n_tests++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse got=%b exp=0", err_valid); end
        drive_instr(0, 32'h304, ok);
        n_tests++; if ({ok, fifo_count} !== {1'b1, 3'd2}) begin
            n_fail++; $display("FAIL illegal_next got ok=%b c=%0d exp ok=1 c=2", ok, fifo_count); end
        out_ready = 1'b1; repeat (3) tick(); out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        accept($urandom, 32'h400, ok);
        tick();
        n = 0;
        while (err_valid !== 1'b1 && n < 40) begin tick(); n++; end
        n_tests++; if (n != TMO) begin n_fail++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TMO); end
        n_tests++; if ({err_code, err_pc} !== {2'b10, 32'h400}) begin
            n_fail++; $display("FAIL timeout_code got code=%b pc=%h exp code=10 pc=400", err_code, err_pc); end
        tick();
    endtask

    task automatic test_overflow();
        bit ok;
        accept($urandom, 32'h500, ok);
        tick();
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b1);
        n_tests++; if ({err_valid, err_code, err_pc, fifo_count} !== {1'b1, 2'b11, 32'h500, 3'd0}) begin
            n_fail++; $display("FAIL overflow_err got v=%b code=%b pc=%h c=%0d exp v=1 code=11 pc=500 c=0",
                               err_valid, err_code, err_pc, fifo_count); end
        tick();
    endtask

    task automatic test_flush();
        bit ok;
        got_err.delete();
        out_ready = 1'b0;
        drive_instr(1, 32'h600, ok);
        accept($urandom, 32'h604, ok);
        tick();
        send_word($urandom, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++; if ({fifo_count, busy, out_valid, err_valid} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL flush_state got c=%0d busy=%b v=%b err=%b exp all 0",
                               fifo_count, busy, out_valid, err_valid); end
        send_word($urandom, 1'b1);
        n_tests++; if ({fifo_count, out_valid} !== {3'd0, 1'b0}) begin
            n_fail++; $display("FAIL flush_late_word got c=%0d v=%b exp c=0 v=0", fifo_count, out_valid); end
        accept($urandom, 32'h610, ok);
        tick();
        xl_illegal = 1'b1; flush = 1'b1;
        tick();
        xl_illegal = 1'b0; flush = 1'b0;
        tick();
        n_tests++; if (got_err.size() != 0) begin
            n_fail++; $display("FAIL flush_no_err got=%0d exp=0 error pulses", got_err.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b0;
        drive_instr(0, 32'h700, ok);
        accept($urandom, 32'h704, ok);
        tick();
        send_word($urandom, 1'b0);
        reset = 1'b1;
        #1;
        n_tests++; if ({out_valid, fifo_count, busy, in_ready, xl_start, err_valid, out_instr, xl_instr} !== '0) begin
            n_fail++; $display("FAIL reset_mid got v=%b c=%0d busy=%b rdy=%b start=%b err=%b oi=%h xi=%h exp all 0",
                               out_valid, fifo_count, busy, in_ready, xl_start, err_valid, out_instr, xl_instr); end
        tick();
        reset = 1'b0;
        tick();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_recover got=%b exp=1", in_ready); end
    endtask

    task automatic test_random();
        bit ok;
        int r, kind, n;
        exp_q.delete(); got_q.delete(); exp_err.delete(); got_err.delete();
        rnd_ready_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 19);
            kind = (r < 7) ? 0 : (r < 13) ? 1 : (r < 16) ? 2 : (r < 19) ? 3 : 4;
            drive_instr(kind, 32'h8000 + t * 4, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL rnd_accept[%0d] got=0 exp=1 (no in_ready)", t); end
        end
        rnd_ready_en = 1'b0;
        @(posedge clk); #1; out_ready = 1'b1;
        n = 0;
        while ((fifo_count != 0 || busy) && n < 200) begin tick(); n++; end
        tick();
        out_ready = 1'b0;
        n_tests++; if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rnd_entry[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (got_err.size() != exp_err.size()) begin
            n_fail++; $display("FAIL rnd_err_count got=%0d exp=%0d", got_err.size(), exp_err.size()); end
        for (int i = 0; i < exp_err.size() && i < got_err.size(); i++) begin
            n_tests++; if (got_err[i] !== exp_err[i]) begin
                n_fail++; $display("FAIL rnd_err[%0d] got=%h exp=%h", i, got_err[i], exp_err[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_word();
        test_backpressure();
        test_illegal();
        test_timeout();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
